// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780-style character LCD write sequencer with optional power-up init
module lcd_ctrl #(
    parameter bit INIT_EN = 1'b1,
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 4,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_rs,
    input  logic [7:0]  i_req_data,
    output logic        o_busy,
    output logic [31:0] o_io_lcd
);

    localparam int T_MAX = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
    localparam int CW    = $clog2(T_MAX) + 1;

    // Each timed state is entered with its duration minus one and leaves at zero.
    localparam logic [CW-1:0] L_PWRUP = CW'(T_PWRUP - 1);
    localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] L_EN    = CW'(T_EN - 1);
    localparam logic [CW-1:0] L_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] L_CMD   = CW'(T_CMD - 1);
    localparam logic [CW-1:0] L_CLR   = CW'(T_CLR - 1);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT,
        S_IDLE,
        S_SETUP,
        S_ENH,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          on;
    logic          en;
    logic          rs;
    logic [7:0]    data;
    logic          ready;
    logic [1:0]    init_idx;
    logic          init_busy;
    logic          long_wait;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Clear and return-home commands need the long execution time.
    assign long_wait = !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_PWRUP;
            cnt       <= L_PWRUP;
            on        <= 1'b0;
            en        <= 1'b0;
            rs        <= 1'b0;
            data      <= 8'h00;
            ready     <= 1'b0;
            init_idx  <= 2'd0;
            init_busy <= 1'b0;
        end else begin
            on <= 1'b1;
            case (state)
                S_PWRUP: begin
                    if (!INIT_EN) begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end else if (cnt == '0) begin
                        state     <= S_INIT;
                        init_busy <= 1'b1;
                        init_idx  <= 2'd0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_INIT: begin
                    rs    <= 1'b0;
                    data  <= init_byte(init_idx);
                    cnt   <= L_SETUP;
                    state <= S_SETUP;
                end
                S_IDLE: begin
                    if (i_req_valid) begin
                        rs    <= i_req_rs;
                        data  <= i_req_data;
                        ready <= 1'b0;
                        cnt   <= L_SETUP;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        en    <= 1'b1;
                        cnt   <= L_EN;
                        state <= S_ENH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_ENH: begin
                    if (cnt == '0) begin
                        en    <= 1'b0;
                        cnt   <= L_HOLD;
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= long_wait ? L_CLR : L_CMD;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        if (init_busy && init_idx != 2'd3) begin
                            init_idx <= init_idx + 2'd1;
                            state    <= S_INIT;
                        end else begin
                            init_busy <= 1'b0;
                            ready     <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_PWRUP;
            endcase
        end
    end

    assign o_req_ready = ready;
    assign o_busy      = ~ready;
    assign o_io_lcd    = {on, 20'b0, en, rs, 1'b0, data};

endmodule
